// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared encodings for the data-memory arbiter.
//   - store-width (WE) encodings driven toward the data memory
//   - load-type (LdType) encodings driven toward the data memory
//   - arbiter FSM state enum
//   - saturating counter helper
package dm_arbiter_pkg;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_BYTE = 2'b11;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    // State records the last winner; D_LOCK is an owned D burst.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_C_OWN  = 2'b01,
        ST_D_OWN  = 2'b10,
        ST_D_LOCK = 2'b11
    } arb_state_t;

    // Increment a 4-bit counter, holding it at lim once reached.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_arbiter_align_chk.sv
// dm_align_chk: combinational natural-alignment check of one access.
// Ports:
//   we        in  2  store width (00 = not a store, so ld applies)
//   ld        in  3  load type, only meaningful when we = 00
//   addr_lo   in  2  byte address bits [1:0]
//   misalign  out 1  word access not 4-aligned or half access not 2-aligned
module dm_align_chk
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] we,
    input  logic [2:0] ld,
    input  logic [1:0] addr_lo,
    output logic       misalign
);

    // A nonzero store width overrides the load type when both are present.
    always_comb begin
        misalign = 1'b0;
        case (we)
            WE_WORD: misalign = (addr_lo != 2'b00);
            WE_HALF: misalign = addr_lo[0];
            WE_BYTE: misalign = 1'b0;
            default: begin
                case (ld)
                    LD_W:        misalign = (addr_lo != 2'b00);
                    LD_H, LD_HU: misalign = addr_lo[0];
                    default:     misalign = 1'b0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates the single-cycle data memory between the CPU MEM
// stage (port C) and a loader/DMA master (port D).
// Grants are combinational from req and registered state; the granted port's
// fields drive the memory directly and the response (rvalid/rport/rdata/rerr)
// is registered, one cycle after the grant.
// Configuration macro: DM_ARB_ROUND_ROBIN_EN -- when defined, a C/D tie outside
// a lock goes to the port that did not win last; otherwise C has fixed
// priority and D is protected only by the starvation force.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   c_req/c_we/c_ld/c_addr/c_wdata/c_pc   CPU request fields
//   d_req/d_we/d_ld/d_addr/d_wdata/d_lock DMA request fields, burst lock
//   c_gnt/d_gnt/c_stall      grant per port, MEM-stage stall
//   rvalid/rport/rdata/rerr  registered response
//   dm_we/dm_ld/dm_pc/dm_addr/dm_wd  memory-side drive
//   dm_rd                    memory read data (already extended per dm_ld)
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        c_req,
    input  logic [1:0]  c_we,
    input  logic [2:0]  c_ld,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [31:0] c_pc,
    input  logic        d_req,
    input  logic [1:0]  d_we,
    input  logic [2:0]  d_ld,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        c_gnt,
    output logic        d_gnt,
    output logic        c_stall,
    output logic        rvalid,
    output logic        rport,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic [1:0]  dm_we,
    output logic [2:0]  dm_ld,
    output logic [31:0] dm_pc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    localparam logic [3:0] MAX_BURST_C    = 4'(MAX_BURST);
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    arb_state_t  state_r;
    logic [3:0]  burst_cnt_r;
    logic [3:0]  starve_cnt_r;
    logic        c_first_r;   // one-shot C priority right after a lock ends

    logic        c_win_s;
    logic        d_win_s;
    logic        force_d_s;
    logic        c_gnt_s;
    logic        d_gnt_s;
    logic        any_gnt_s;
    logic        misalign_s;
    logic [1:0]  sel_we_s;
    logic [2:0]  sel_ld_s;
    logic [31:0] sel_pc_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wd_s;

    logic        rvalid_r;
    logic        rport_r;
    logic        rerr_r;
    logic [31:0] rdata_r;

    // Choose the winner: lock ownership, then starvation force, then C, then D.
    always_comb begin
        c_win_s   = 1'b0;
        d_win_s   = 1'b0;
        force_d_s = d_req & (starve_cnt_r == STARVE_LIMIT_C);
        case (state_r)
            ST_D_LOCK: begin
                if (d_req) begin
                    d_win_s = 1'b1;
                end else if (c_req) begin
                    c_win_s = 1'b1;
                end else begin
                    d_win_s = 1'b0;
                end
            end
            default: begin
                if (force_d_s) begin
                    d_win_s = 1'b1;
                end else if (c_req & d_req) begin
                    if (c_first_r) begin
                        c_win_s = 1'b1;
`ifdef DM_ARB_ROUND_ROBIN_EN
                    end else if (state_r == ST_C_OWN) begin
                        d_win_s = 1'b1;
`endif
                    end else begin
                        c_win_s = 1'b1;
                    end
                end else if (c_req) begin
                    c_win_s = 1'b1;
                end else if (d_req) begin
                    d_win_s = 1'b1;
                end else begin
                    d_win_s = 1'b0;
                end
            end
        endcase
    end

    // No grant may issue while reset is held, so nothing commits in that cycle.
    assign c_gnt_s   = c_win_s & ~RESET;
    assign d_gnt_s   = d_win_s & ~RESET;
    assign any_gnt_s = c_gnt_s | d_gnt_s;

    // Route the granted port's fields to the memory; zero when idle.
    always_comb begin
        sel_we_s   = WE_NONE;
        sel_ld_s   = LD_W;
        sel_pc_s   = 32'h0;
        sel_addr_s = 32'h0;
        sel_wd_s   = 32'h0;
        if (c_gnt_s) begin
            sel_we_s   = c_we;
            sel_ld_s   = c_ld;
            sel_pc_s   = c_pc;
            sel_addr_s = c_addr;
            sel_wd_s   = c_wdata;
        end else if (d_gnt_s) begin
            sel_we_s   = d_we;
            sel_ld_s   = d_ld;
            sel_pc_s   = 32'h0;
            sel_addr_s = d_addr;
            sel_wd_s   = d_wdata;
        end else begin
            sel_we_s   = WE_NONE;
        end
    end

    dm_align_chk u_align (
        .we       (sel_we_s),
        .ld       (sel_ld_s),
        .addr_lo  (sel_addr_s[1:0]),
        .misalign (misalign_s)
    );

    assign c_gnt   = c_gnt_s;
    assign d_gnt   = d_gnt_s;
    assign c_stall = c_req & ~c_gnt_s & ~RESET;
    assign dm_we   = misalign_s ? WE_NONE : sel_we_s;
    assign dm_ld   = sel_ld_s;
    assign dm_pc   = sel_pc_s;
    assign dm_addr = sel_addr_s;
    assign dm_wd   = sel_wd_s;

    // Arbiter FSM: track last winner, lock bursts and post-lock C priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= 4'd0;
            c_first_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_D_LOCK: begin
                    // Leave on lock release or when this grant fills the burst.
                    if (~d_lock | (d_gnt_s & ((burst_cnt_r + 4'd1) >= MAX_BURST_C))) begin
                        state_r     <= ST_C_OWN;
                        burst_cnt_r <= 4'd0;
                        c_first_r   <= 1'b1;
                    end else if (d_gnt_s) begin
                        burst_cnt_r <= burst_cnt_r + 4'd1;
                    end else begin
                        burst_cnt_r <= burst_cnt_r;
                    end
                end
                default: begin
                    if (d_gnt_s & d_lock) begin
                        // A one-beat burst is already complete on entry.
                        if (MAX_BURST_C <= 4'd1) begin
                            state_r     <= ST_C_OWN;
                            burst_cnt_r <= 4'd0;
                            c_first_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_D_LOCK;
                            burst_cnt_r <= 4'd1;
                            c_first_r   <= 1'b0;
                        end
                    end else if (d_gnt_s) begin
                        state_r   <= ST_D_OWN;
                        c_first_r <= 1'b0;
                    end else if (c_gnt_s) begin
                        state_r   <= ST_C_OWN;
                        c_first_r <= 1'b0;
                    end else begin
                        state_r   <= state_r;
                    end
                end
            endcase
        end
    end

    // Starvation counter and the registered response to the winner.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt_r <= 4'd0;
            rvalid_r     <= 1'b0;
            rport_r      <= 1'b0;
            rerr_r       <= 1'b0;
            rdata_r      <= 32'h0;
        end else begin
            if (d_gnt_s) begin
                starve_cnt_r <= 4'd0;
            end else if (d_req) begin
                starve_cnt_r <= sat_inc4(starve_cnt_r, STARVE_LIMIT_C);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            rvalid_r <= any_gnt_s;
            rport_r  <= d_gnt_s;
            rerr_r   <= misalign_s;
            // Stores, misaligned accesses and idle cycles return zero data.
            if (any_gnt_s & ~misalign_s & (sel_we_s == WE_NONE)) begin
                rdata_r <= dm_rd;
            end else begin
                rdata_r <= 32'h0;
            end
        end
    end

    assign rvalid = rvalid_r;
    assign rport  = rport_r;
    assign rerr   = rerr_r;
    assign rdata  = rdata_r;

endmodule
